// File: rtl/data_break_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | data_break_arbiter_pkg: shared CPU constants for the data-break     |
// | arbiter (state encodings, word width, burst default).  Rev 1.0      |
// +--------------------------------------------------------------------+
package data_break_arbiter_pkg;

    localparam int DBA_DW               = 12;
    localparam int DBA_MAXBURST_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAITCPU = 3'd1,
        ST_READ    = 3'd2,
        ST_LATCH   = 3'd3,
        ST_WRITE   = 3'd4,
        ST_ACK     = 3'd5,
        ST_YIELD   = 3'd6
    } dba_state_e;

endpackage

`default_nettype wire

// File: rtl/data_break_arbiter_incrementer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | data_break_arbiter_incrementer: 12-bit INCREMENTER, q = d + INC,    |
// | forced to zero when OE is low.  Rev 1.0                             |
// +--------------------------------------------------------------------+
module data_break_arbiter_incrementer
    import data_break_arbiter_pkg::*;
(
    input  logic              inc_i,
    input  logic              oe_i,
    input  logic [DBA_DW-1:0] d_i,
    output logic [DBA_DW-1:0] q_o
);

    // The carry out is not brought out: wrap is detected from a zero result.
    assign q_o = oe_i ? (d_i + DBA_DW'(inc_i)) : '0;

endmodule

`default_nettype wire

// File: rtl/data_break_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | data_break_arbiter: stalls the CPU at an instruction boundary and   |
// | runs read / write / increment data breaks on the RAM.  Rev 1.0      |
// +--------------------------------------------------------------------+
module data_break_arbiter
    import data_break_arbiter_pkg::*;
#(
    parameter int MAXBURST = DBA_MAXBURST_DEFAULT
)
(
    input  logic              SYSCLK,
    input  logic              sw_RESET,
    input  logic              cpuIdle,
    output logic              cpuHold,
    input  logic              dbRq,
    input  logic [DBA_DW-1:0] dbAddr,
    input  logic              dbWrite,
    input  logic              dbInc,
    input  logic [DBA_DW-1:0] dbWData,
    output logic              dbAck,
    output logic [DBA_DW-1:0] dbRData,
    output logic              dbOverflow,
    output logic [DBA_DW-1:0] ramAddr,
    output logic [DBA_DW-1:0] ramWData,
    output logic              ramOE,
    output logic              ramWE,
    input  logic [DBA_DW-1:0] ramRData
);

    localparam int CNT_W = $clog2(MAXBURST + 1);

    dba_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hold_q, hold_d;
    logic              ack_q, ack_d;
    logic              oe_q, oe_d;
    logic              we_q, we_d;
    logic              ovf_q, ovf_d;
    logic              inc_op_q, inc_op_d;
    logic [DBA_DW-1:0] addr_q, addr_d;
    logic [DBA_DW-1:0] wdata_q, wdata_d;
    logic [DBA_DW-1:0] rdata_q, rdata_d;
    logic [DBA_DW-1:0] inc_sum;

    // Fed straight from the RAM so the sum is ready on the edge that enters WRITE.
    data_break_arbiter_incrementer u_inc (
        .inc_i (1'b1),
        .oe_i  (1'b1),
        .d_i   (ramRData),
        .q_o   (inc_sum)
    );

    always_ff @(posedge SYSCLK) begin
        if (!sw_RESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hold_q   <= 1'b0;
            ack_q    <= 1'b0;
            oe_q     <= 1'b0;
            we_q     <= 1'b0;
            ovf_q    <= 1'b0;
            inc_op_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            ack_q    <= ack_d;
            oe_q     <= oe_d;
            we_q     <= we_d;
            ovf_q    <= ovf_d;
            inc_op_q <= inc_op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        ack_d    = 1'b0;
        oe_d     = 1'b0;
        we_d     = 1'b0;
        ovf_d    = ovf_q;
        inc_op_d = inc_op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (dbRq) begin
                    state_d = ST_WAITCPU;
                    hold_d  = 1'b1;
                end
            end
            ST_WAITCPU: begin
                // A non-zero count means a burst just ended here, so yield the CPU.
                if (!dbRq) begin
                    hold_d = 1'b0;
                    if (cnt_q != '0) begin
                        state_d = ST_YIELD;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (cpuIdle) begin
                    addr_d   = dbAddr;
                    wdata_d  = dbWData;
                    inc_op_d = dbInc;
                    ovf_d    = 1'b0;
                    if (dbInc || !dbWrite) begin
                        state_d = ST_READ;
                        oe_d    = 1'b1;
                    end else begin
                        state_d = ST_WRITE;
                        we_d    = 1'b1;
                    end
                end
            end
            ST_READ: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                rdata_d = ramRData;
                if (inc_op_q) begin
                    state_d = ST_WRITE;
                    we_d    = 1'b1;
                    wdata_d = inc_sum;
                    ovf_d   = (inc_sum == '0);
                end else begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                end
            end
            ST_WRITE: begin
                state_d = ST_ACK;
                ack_d   = 1'b1;
            end
            ST_ACK: begin
                if (cnt_q == CNT_W'(MAXBURST - 1)) begin
                    state_d = ST_YIELD;
                    hold_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_WAITCPU;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_YIELD: begin
                if (!cpuIdle) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = 1'b0;
            end
        endcase
    end

    assign cpuHold    = hold_q;
    assign dbAck      = ack_q;
    assign dbRData    = rdata_q;
    assign dbOverflow = ovf_q;
    assign ramAddr    = addr_q;
    assign ramWData   = wdata_q;
    assign ramOE      = oe_q;
    assign ramWE      = we_q;

endmodule

`default_nettype wire

// File: tb/tb_data_break_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_data_break_arbiter: directed bench with a RAM model for the      |
// | data-break arbiter.  Rev 1.0                                        |
// +--------------------------------------------------------------------+
module tb_data_break_arbiter;

    logic        clk = 1'b0;
    logic        sw_RESET;
    logic        cpuIdle;
    logic        cpuHold;
    logic        dbRq;
    logic [11:0] dbAddr;
    logic        dbWrite;
    logic        dbInc;
    logic [11:0] dbWData;
    logic        dbAck;
    logic [11:0] dbRData;
    logic        dbOverflow;
    logic [11:0] ramAddr;
    logic [11:0] ramWData;
    logic        ramOE;
    logic        ramWE;
    logic [11:0] ramRData = '0;

    logic [11:0] mem [0:4095];
    int n_oe = 0, n_we = 0, n_both = 0, n_ack = 0;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    data_break_arbiter #(.MAXBURST(4)) dut (
        .SYSCLK     (clk),
        .sw_RESET   (sw_RESET),
        .cpuIdle    (cpuIdle),
        .cpuHold    (cpuHold),
        .dbRq       (dbRq),
        .dbAddr     (dbAddr),
        .dbWrite    (dbWrite),
        .dbInc      (dbInc),
        .dbWData    (dbWData),
        .dbAck      (dbAck),
        .dbRData    (dbRData),
        .dbOverflow (dbOverflow),
        .ramAddr    (ramAddr),
        .ramWData   (ramWData),
        .ramOE      (ramOE),
        .ramWE      (ramWE),
        .ramRData   (ramRData)
    );

    // Synchronous RAM: read data appears the cycle after an OE cycle.
    always @(posedge clk) begin
        if (ramWE === 1'b1) mem[ramAddr] = ramWData;
        if (ramOE === 1'b1) ramRData <= mem[ramAddr];
    end

    always @(posedge clk) begin
        if (ramOE === 1'b1) n_oe++;
        if (ramWE === 1'b1) n_we++;
        if (ramOE === 1'b1 && ramWE === 1'b1) n_both++;
        if (dbAck === 1'b1) n_ack++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(output int lat);
        lat = 0;
        while (lat < 12) begin
            @(negedge clk);
            lat++;
            if (dbAck === 1'b1) break;
        end
    endtask

    task automatic cpu_step();
        cpuIdle = 1'b0;
        @(negedge clk);
        cpuIdle = 1'b1;
    endtask

    task automatic do_req(input string tag, input logic [11:0] a, input logic w,
                          input logic inc, input logic [11:0] wd, input int exp_lat);
        int lat;
        dbAddr = a; dbWrite = w; dbInc = inc; dbWData = wd; dbRq = 1'b1;
        @(negedge clk);
        chk({tag, "_hold"}, 32'(cpuHold), 32'd1);
        wait_ack(lat);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        dbRq = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_hold_drop"}, 32'(cpuHold), 32'd0);
        cpu_step();
    endtask

    initial begin
        int oe0, we0, ack0, acks, lat;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        sw_RESET = 1'b0; cpuIdle = 1'b1; dbRq = 1'b0; dbAddr = '0;
        dbWrite = 1'b0; dbInc = 1'b0; dbWData = '0;
        repeat (3) @(negedge clk);
        chk("rst_hold", 32'(cpuHold), 32'd0);
        chk("rst_ack", 32'(dbAck), 32'd0);
        chk("rst_oe", 32'(ramOE), 32'd0);
        chk("rst_we", 32'(ramWE), 32'd0);
        chk("rst_ovf", 32'(dbOverflow), 32'd0);
        chk("rst_addr", 32'(ramAddr), 32'o0);
        chk("rst_wdata", 32'(ramWData), 32'o0);
        chk("rst_rdata", 32'(dbRData), 32'o0);
        sw_RESET = 1'b1;
        @(negedge clk);

        mem[12'o0200] = 12'o1234;
        oe0 = n_oe; we0 = n_we;
        do_req("read", 12'o0200, 1'b0, 1'b0, 12'o0, 3);
        chk("read_data", 32'(dbRData), 32'o1234);
        chk("read_oe_pulses", 32'(n_oe - oe0), 32'd1);
        chk("read_we_pulses", 32'(n_we - we0), 32'd0);

        oe0 = n_oe; we0 = n_we;
        do_req("write", 12'o0300, 1'b1, 1'b0, 12'o5555, 2);
        chk("write_ram", 32'(mem[12'o0300]), 32'o5555);
        chk("write_we_pulses", 32'(n_we - we0), 32'd1);
        chk("write_oe_pulses", 32'(n_oe - oe0), 32'd0);

        mem[12'o0100] = 12'o7777;
        oe0 = n_oe; we0 = n_we;
        do_req("inc_wrap", 12'o0100, 1'b0, 1'b1, 12'o0, 4);
        chk("inc_wrap_ram", 32'(mem[12'o0100]), 32'o0);
        chk("inc_wrap_rdata", 32'(dbRData), 32'o7777);
        chk("inc_wrap_ovf", 32'(dbOverflow), 32'd1);
        chk("inc_wrap_pulses", 32'(n_oe - oe0 + n_we - we0), 32'd2);

        mem[12'o0100] = 12'o0005;
        do_req("inc_plain", 12'o0100, 1'b1, 1'b1, 12'o3333, 4);
        chk("inc_plain_ram", 32'(mem[12'o0100]), 32'o0006);
        chk("inc_plain_rdata", 32'(dbRData), 32'o0005);
        chk("inc_plain_ovf", 32'(dbOverflow), 32'd0);

        // Write data changed while waiting for the CPU: only the captured value lands.
        cpuIdle = 1'b0;
        dbAddr = 12'o0600; dbWrite = 1'b1; dbInc = 1'b0; dbWData = 12'o1111; dbRq = 1'b1;
        @(negedge clk);
        @(negedge clk);
        dbWData = 12'o6543; cpuIdle = 1'b1;
        wait_ack(lat);
        chk("late_data_latency", 32'(lat), 32'd2);
        chk("late_data_ram", 32'(mem[12'o0600]), 32'o6543);
        dbRq = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cpu_step();

        // Request withdrawn before the CPU reaches a boundary.
        oe0 = n_oe; we0 = n_we;
        cpuIdle = 1'b0;
        dbAddr = 12'o0300; dbWrite = 1'b1; dbWData = 12'o7000; dbRq = 1'b1;
        @(negedge clk);
        chk("withdraw_hold_up", 32'(cpuHold), 32'd1);
        @(negedge clk);
        dbRq = 1'b0;
        @(negedge clk);
        chk("withdraw_hold_down", 32'(cpuHold), 32'd0);
        chk("withdraw_no_access", 32'(n_oe - oe0 + n_we - we0), 32'd0);
        chk("withdraw_ram", 32'(mem[12'o0300]), 32'o5555);
        cpuIdle = 1'b1;
        @(negedge clk);

        // Burst of six back-to-back reads with MAXBURST=4.
        ack0 = n_ack;
        dbAddr = 12'o0200; dbWrite = 1'b0; dbInc = 1'b0; dbRq = 1'b1;
        repeat (40) @(negedge clk);
        chk("burst_first_acks", 32'(n_ack - ack0), 32'd4);
        chk("burst_yield_hold", 32'(cpuHold), 32'd0);
        cpu_step();
        acks = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (dbAck === 1'b1) begin
                acks++;
                if (acks == 2) dbRq = 1'b0;
            end
        end
        chk("burst_second_acks", 32'(acks), 32'd2);
        chk("burst_end_hold", 32'(cpuHold), 32'd0);
        cpu_step();

        // Reset arrives just as an increment is about to write back.
        mem[12'o0500] = 12'o0042;
        we0 = n_we;
        dbAddr = 12'o0500; dbWrite = 1'b0; dbInc = 1'b1; dbRq = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rstinc_read_cycle", 32'(ramOE), 32'd1);
        @(negedge clk);
        sw_RESET = 1'b0;
        @(negedge clk);
        chk("rstinc_hold", 32'(cpuHold), 32'd0);
        chk("rstinc_we", 32'(ramWE), 32'd0);
        chk("rstinc_ack", 32'(dbAck), 32'd0);
        chk("rstinc_addr", 32'(ramAddr), 32'o0);
        chk("rstinc_rdata", 32'(dbRData), 32'o0);
        sw_RESET = 1'b1; dbRq = 1'b0; dbInc = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstinc_no_write", 32'(n_we - we0), 32'd0);
        chk("rstinc_ram", 32'(mem[12'o0500]), 32'o0042);
        chk("oe_we_exclusive", 32'(n_both), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
